crossy_game_ctrl: RTL and testbench
===================================

CROSSY_GAME_CTRL -- requirements
Module: crossy_game_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 10, number of player columns (2..16).
REQ-002 SHALL have parameter START_COL, default 4, player column after reset and on every game restart.
REQ-003 SHALL have parameter COOLDOWN, default 8, frames of move lockout after an accepted move (0..15).
REQ-004 SHALL have parameter DEATH_FRAMES, default 60, frames spent in DYING (1..255).
REQ-005 clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-006 sys_rst  in  1  asynchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame (start of vblank); all game updates SHALL occur only on this pulse.
REQ-008 move  in  4  button levels {up,down,left,right}, bit3 = up.
REQ-009 collision  in  1  player/car overlap from the render datapath, valid any cycle.
REQ-010 game_state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-011 player_col  out  4  player column, 0..COLS-1.
REQ-012 world_row  out  10  player's current row in world space.
REQ-013 score  out  10  highest row reached this game.
REQ-014 move_pulse  out  1  one-cycle pulse when a move is applied.
REQ-015 move_dir  out  2  direction of the last applied move: up=0, down=1, left=2, right=3.
REQ-016 flash  out  1  player blink enable during DYING.

Function
REQ-017 Button sampling SHALL occur on frame_tick: move_prev <= move; new_press = move & ~move_prev. A level held across frames SHALL produce exactly one new_press.
REQ-018 When several new_press bits are set on one tick, priority SHALL be up > down > left > right; only one move SHALL be applied per tick.
REQ-019 IDLE: on a tick with any new_press, state SHALL go to PLAY; the starting press SHALL NOT be applied as a move.
REQ-020 PLAY collision latch: collision asserted in any PLAY cycle SHALL set a sticky hit flag. The flag SHALL be cleared on entry to PLAY and ignored in all other states.
REQ-021 PLAY tick with hit flag set: state SHALL go to DYING, death counter SHALL load DEATH_FRAMES, and no move SHALL be applied (collision wins over a simultaneous move).
REQ-022 PLAY tick, no hit, cooldown != 0: cooldown SHALL decrement; new_press SHALL be discarded, not queued.
REQ-023 PLAY tick, no hit, cooldown == 0, new_press present: the selected move SHALL be applied if legal. A legal move SHALL set cooldown = COOLDOWN.
REQ-024 up SHALL be legal if world_row < 1023. It SHALL set world_row+1 and score = max(score, world_row+1).
REQ-025 down SHALL be legal if world_row != 0 and (score - world_row) < 3. It SHALL set world_row-1.
REQ-026 left SHALL be legal if player_col != 0 (col-1). right SHALL be legal if player_col != COLS-1 (col+1).
REQ-027 An illegal move SHALL change no state, SHALL NOT load cooldown and SHALL NOT pulse move_pulse.
REQ-028 move_pulse SHALL be high for exactly the one cycle after the tick that applied the move. move_dir SHALL update in that same cycle and hold until the next applied move.
REQ-029 DYING: each tick SHALL decrement the death counter; the tick on which it reaches 0 SHALL move state to OVER. flash SHALL equal death counter bit 2 in DYING and 0 otherwise.
REQ-030 OVER: score SHALL be held. On a tick with any new_press, state SHALL go to IDLE, setting player_col=START_COL, world_row=0, score=0, cooldown=0.
REQ-031 frame_tick coinciding with collision in the same cycle SHALL treat that collision as latched for that tick.
REQ-032 Outputs SHALL be registered; game_state SHALL change in the cycle after the deciding tick.

Reset
REQ-033 sys_rst SHALL immediately force: game_state=IDLE, player_col=START_COL, world_row=0, score=0, move_pulse=0, move_dir=0, flash=0, cooldown=0, death counter=0, hit flag=0, move_prev=4'b1111 (buttons held through reset SHALL not count as presses).
REQ-034 Reset asserted mid-game or mid-DYING SHALL abandon all progress, with no partial update on the release edge.

Verification
REQ-035 Reset, then tick with move=0 followed by tick with move=4'b1000 -> PLAY. Next tick with up pressed fresh -> world_row=1, score=1, move_pulse one cycle, move_dir=0.
REQ-036 PLAY, up accepted at tick N, right pressed fresh at ticks N+1..N+8 -> ignored. Right pressed fresh at N+9 -> player_col=5.
REQ-037 player_col=0, left press -> no change, no move_pulse, cooldown not loaded. Immediate right on the next tick -> accepted.
REQ-038 world_row=score=5, three downs spaced by cooldown -> world_row=2. Fourth down -> rejected, score stays 5.
REQ-039 One-cycle collision between ticks plus up press at next tick -> DYING, no move, flash toggles every 4 ticks. After 60 ticks -> OVER with score held. Press -> IDLE with all counters cleared.
REQ-040 Buttons 4'b1111 held through reset release -> stays IDLE; up+left pressed fresh together in PLAY -> only up applied.

Source files
------------

// File: rtl/crossy_game_ctrl_if.sv
// crossy_game_ctrl_if: frame/button/collision inputs and game-status outputs of the crossy game controller
// master drives frame_tick, move and collision and observes the status; slave is the controller
interface crossy_game_ctrl_if;
    logic       frame_tick;
    logic [3:0] move;
    logic       collision;
    logic [1:0] game_state;
    logic [3:0] player_col;
    logic [9:0] world_row;
    logic [9:0] score;
    logic       move_pulse;
    logic [1:0] move_dir;
    logic       flash;
    modport master (
        output frame_tick, move, collision,
        input  game_state, player_col, world_row, score, move_pulse, move_dir, flash
    );
    modport slave (
        input  frame_tick, move, collision,
        output game_state, player_col, world_row, score, move_pulse, move_dir, flash
    );
endinterface

// File: rtl/crossy_game_ctrl.sv
// crossy_game_ctrl: per-frame player movement, collision, death and restart state machine
// clk/sys_rst (async, active high); bus.slave: frame_tick, move{up,down,left,right}, collision in;
// game_state, player_col, world_row, score, move_pulse, move_dir, flash out (all registered)
module crossy_game_ctrl #(
    parameter int COLS         = 10,
    parameter int START_COL    = 4,
    parameter int COOLDOWN     = 8,
    parameter int DEATH_FRAMES = 60
) (
    input logic               clk,
    input logic               sys_rst,
    crossy_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;
    state_t     state, state_n;
    logic [3:0] col, col_n, cd, cd_n, move_prev, press;
    logic [9:0] row, row_n, score, score_n, row_up;
    logic [7:0] death, death_n;
    logic [1:0] dir, dir_n, sel;
    logic       hit, hit_n, hit_now, pulse, pulse_n, flash, flash_n, legal;
    assign press   = bus.move & ~move_prev;
    assign sel     = press[3] ? 2'd0 : press[2] ? 2'd1 : press[1] ? 2'd2 : 2'd3;
    assign row_up  = row + 10'd1;
    assign legal   = sel == 2'd0 ? row != 10'h3ff :
                     sel == 2'd1 ? (row != 10'd0 && score - row < 10'd3) :
                     sel == 2'd2 ? col != 4'd0 : col != 4'(COLS - 1);
    // a collision on the deciding tick itself counts as already latched
    assign hit_now = state == PLAY && (hit || bus.collision);
    assign hit_n   = hit_now && state_n == PLAY;
    assign flash_n = state_n == DYING && death_n[2];
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        score_n = score;
        cd_n    = cd;
        death_n = death;
        dir_n   = dir;
        pulse_n = 1'b0;
        if (bus.frame_tick) begin
            case (state)
                IDLE: state_n = |press ? PLAY : IDLE;
                PLAY: begin
                    if (hit_now) begin
                        state_n = DYING;
                        death_n = 8'(DEATH_FRAMES);
                    end else if (cd != 4'd0) begin
                        cd_n = cd - 4'd1;
                    end else if (|press && legal) begin
                        cd_n    = 4'(COOLDOWN);
                        pulse_n = 1'b1;
                        dir_n   = sel;
                        row_n   = sel == 2'd0 ? row_up : sel == 2'd1 ? row - 10'd1 : row;
                        col_n   = sel == 2'd2 ? col - 4'd1 : sel == 2'd3 ? col + 4'd1 : col;
                        score_n = sel == 2'd0 && row_up > score ? row_up : score;
                    end
                end
                DYING: begin
                    death_n = death - 8'd1;
                    state_n = death == 8'd1 ? OVER : DYING;
                end
                default: if (|press) begin
                    state_n = IDLE;
                    col_n   = 4'(START_COL);
                    row_n   = 10'd0;
                    score_n = 10'd0;
                    cd_n    = 4'd0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            col       <= 4'(START_COL);
            row       <= 10'd0;
            score     <= 10'd0;
            cd        <= 4'd0;
            death     <= 8'd0;
            dir       <= 2'd0;
            hit       <= 1'b0;
            pulse     <= 1'b0;
            flash     <= 1'b0;
            move_prev <= 4'hf;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            score     <= score_n;
            cd        <= cd_n;
            death     <= death_n;
            dir       <= dir_n;
            hit       <= hit_n;
            pulse     <= pulse_n;
            flash     <= flash_n;
            move_prev <= bus.frame_tick ? bus.move : move_prev;
        end
    end
    assign bus.game_state = state;
    assign bus.player_col = col;
    assign bus.world_row  = row;
    assign bus.score      = score;
    assign bus.move_pulse = pulse;
    assign bus.move_dir   = dir;
    assign bus.flash      = flash;
endmodule

// File: tb/tb_crossy_game_ctrl.sv
// tb_crossy_game_ctrl: scoreboard bench with a rule-level game model and directed plus random stimulus
module tb_crossy_game_ctrl;
    localparam int COLS = 10, START_COL = 4, COOLDOWN = 8, DEATH = 60;
    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    crossy_game_ctrl_if bus();
    crossy_game_ctrl #(.COLS(COLS), .START_COL(START_COL), .COOLDOWN(COOLDOWN), .DEATH_FRAMES(DEATH))
        dut (.clk(clk), .sys_rst(sys_rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {int idx; string name; int f[7];} want_t;
    logic [29:0] exp_q[$];
    want_t       want_q[$];
    int total = 0, bad = 0, n_push = 0, n_pop = 0;

    int m_st, m_col, m_row, m_score, m_cd, m_death, m_dir, m_pulse, m_flash;
    bit m_hit;
    logic [3:0] m_prev;

    function automatic logic [29:0] pack(int st, int col, int row, int score, int pulse, int dir, int flash);
        return {st[1:0], col[3:0], row[9:0], score[9:0], pulse[0], dir[1:0], flash[0]};
    endfunction

    function automatic string fmt(logic [29:0] v);
        return $sformatf("st=%0d col=%0d row=%0d score=%0d pulse=%0d dir=%0d flash=%0d",
                         v[29:28], v[27:24], v[23:14], v[13:4], v[3], v[2:1], v[0]);
    endfunction

    // direction codes: 0 up, 1 down, 2 left, 3 right
    function automatic bit can_go(int d);
        case (d)
            0:       return m_row < 1023;
            1:       return m_row > 0 && m_score - m_row < 3;
            2:       return m_col > 0;
            default: return m_col < COLS - 1;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_col = START_COL; m_row = 0; m_score = 0; m_cd = 0; m_death = 0;
        m_hit = 0; m_prev = 4'hf; m_pulse = 0; m_dir = 0; m_flash = 0;
    endtask

    task automatic model_cycle(input bit t, input logic [3:0] mv, input bit c);
        bit hit_now;
        logic [3:0] fresh;
        int d;
        hit_now = m_st == 1 && (m_hit || c);
        m_pulse = 0;
        if (t) begin
            fresh = mv & ~m_prev;
            m_prev = mv;
            d = -1;
            for (int i = 0; i < 4; i++) if (d < 0 && fresh[3 - i]) d = i;
            if (m_st == 0) begin
                if (d >= 0) m_st = 1;
            end else if (m_st == 1) begin
                if (hit_now) begin
                    m_st = 2;
                    m_death = DEATH;
                end else if (m_cd > 0) begin
                    m_cd--;
                end else if (d >= 0 && can_go(d)) begin
                    m_cd = COOLDOWN;
                    m_pulse = 1;
                    m_dir = d;
                    if (d == 0) m_row++;
                    if (d == 1) m_row--;
                    if (d == 2) m_col--;
                    if (d == 3) m_col++;
                    if (m_row > m_score) m_score = m_row;
                end
            end else if (m_st == 2) begin
                m_death--;
                if (m_death == 0) m_st = 3;
            end else if (d >= 0) begin
                m_st = 0; m_col = START_COL; m_row = 0; m_score = 0; m_cd = 0;
            end
        end
        m_hit = hit_now && m_st == 1;
        m_flash = (m_st == 2) ? (m_death >> 2) & 1 : 0;
    endtask

    task automatic step(input bit r, input bit t, input logic [3:0] mv, input bit c);
        @(negedge clk);
        sys_rst = r;
        bus.frame_tick = t;
        bus.move = mv;
        bus.collision = c;
        if (r) model_reset();
        else model_cycle(t, mv, c);
        exp_q.push_back(pack(m_st, m_col, m_row, m_score, m_pulse, m_dir, m_flash));
        n_push++;
    endtask

    task automatic tk(input logic [3:0] mv);
        step(0, 1, mv, 0);
    endtask

    task automatic press(input logic [3:0] mv);
        tk(mv);
        repeat (COOLDOWN) tk(4'h0);
    endtask

    task automatic want(input string name, input int st, input int col, input int row, input int score,
                        input int pulse, input int dir, input int flash);
        want_t w;
        w.idx = n_push - 1;
        w.name = name;
        w.f = '{st, col, row, score, pulse, dir, flash};
        want_q.push_back(w);
    endtask

    logic [29:0] mon_exp, mon_act;
    int act_f[7];
    want_t mon_w;
    bit mon_ok;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {bus.game_state, bus.player_col, bus.world_row, bus.score,
                       bus.move_pulse, bus.move_dir, bus.flash};
            act_f = '{int'(bus.game_state), int'(bus.player_col), int'(bus.world_row), int'(bus.score),
                      int'(bus.move_pulse), int'(bus.move_dir), int'(bus.flash)};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL cycle %0d: got %s want %s", n_pop, fmt(mon_act), fmt(mon_exp));
            end
            while (want_q.size() != 0 && want_q[0].idx == n_pop) begin
                mon_w = want_q.pop_front();
                mon_ok = 1;
                for (int i = 0; i < 7; i++) if (mon_w.f[i] >= 0 && mon_w.f[i] != act_f[i]) mon_ok = 0;
                total++;
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL %s: got %s want st/col/row/score/pulse/dir/flash=%0d/%0d/%0d/%0d/%0d/%0d/%0d (-1 = any)",
                             mon_w.name, fmt(mon_act), mon_w.f[0], mon_w.f[1], mon_w.f[2], mon_w.f[3],
                             mon_w.f[4], mon_w.f[5], mon_w.f[6]);
                end
            end
            n_pop++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, t, c;
        logic [3:0] mv;
        bus.frame_tick = 1'b0;
        bus.move = 4'hf;
        bus.collision = 1'b0;
        model_reset();
        repeat (3) step(1, 0, 4'hf, 0);
        want("reset_values", 0, START_COL, 0, 0, 0, 0, 0);
        tk(4'hf);
        want("held_through_reset", 0, START_COL, 0, 0, 0, 0, 0);
        tk(4'h0);
        tk(4'b1000);
        want("start_press_not_move", 1, START_COL, 0, 0, 0, 0, 0);
        tk(4'h0);
        tk(4'b1000);
        want("first_up", 1, 4, 1, 1, 1, 0, 0);
        step(0, 0, 4'b1000, 0);
        want("pulse_one_cycle", 1, 4, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tk((i % 2) ? 4'b0001 : 4'b0000);
            want("cooldown_discard", 1, 4, 1, 1, 0, 0, -1);
        end
        tk(4'b0001);
        want("cooldown_expired_right", 1, 5, 1, 1, 1, 3, 0);
        repeat (COOLDOWN) tk(4'h0);
        repeat (5) press(4'b0010);
        want("walk_to_col0", 1, 0, 1, 1, 0, 2, -1);
        tk(4'b0010);
        want("left_wall_rejected", 1, 0, 1, 1, 0, 2, 0);
        tk(4'b0001);
        want("right_after_wall", 1, 1, 1, 1, 1, 3, 0);
        repeat (COOLDOWN) tk(4'h0);
        repeat (4) press(4'b1000);
        want("climb_to_5", 1, 1, 5, 5, 0, 0, -1);
        repeat (3) press(4'b0100);
        want("three_downs", 1, 1, 2, 5, 0, 1, -1);
        tk(4'b0100);
        want("fourth_down_rejected", 1, 1, 2, 5, 0, 1, 0);
        step(0, 0, 4'h0, 1);
        step(0, 0, 4'h0, 0);
        tk(4'b1000);
        want("collision_wins", 2, 1, 2, 5, 0, 1, 1);
        repeat (DEATH - 1) tk(4'h0);
        want("still_dying", 2, 1, 2, 5, 0, 1, 0);
        tk(4'h0);
        want("over_score_held", 3, 1, 2, 5, 0, 1, 0);
        tk(4'b0010);
        want("restart_idle", 0, START_COL, 0, 0, 0, -1, 0);
        tk(4'h0);
        tk(4'b1000);
        tk(4'h0);
        tk(4'b1010);
        want("up_beats_left", 1, START_COL, 1, 1, 1, 0, -1);
        tk(4'h0);
        step(0, 0, 4'h0, 0);
        step(1, 0, 4'hf, 0);
        want("midgame_reset", 0, START_COL, 0, 0, 0, 0, 0);
        step(1, 1, 4'hf, 0);
        tk(4'hf);
        want("idle_after_reset_held", 0, START_COL, 0, 0, 0, 0, 0);
        tk(4'h0);
        tk(4'b1000);
        step(0, 0, 4'h0, 1);
        tk(4'h0);
        want("dying_entry", 2, START_COL, 0, 0, 0, 0, 1);
        repeat (5) tk(4'h0);
        step(1, 0, 4'h0, 0);
        want("dying_reset", 0, START_COL, 0, 0, 0, 0, 0);
        repeat (4000) begin
            r = $urandom_range(0, 599) == 0;
            t = $urandom_range(0, 1) == 1;
            mv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            c = $urandom_range(0, 59) == 0;
            step(r, t, mv, c);
        end
        step(0, 0, 4'h0, 0);
        step(0, 0, 4'h0, 0);
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
